// File: rtl/cgra_config_loader.sv
// cgra_config_loader: buffers host config words, replays them onto the CGRA config bus,
// waits a settle period, then times the run window. Optional macro: CFG_CHECKSUM_EN.
module cgra_config_loader #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int CNT_W          = 65,
  parameter int MAX_RUN_CYCLES = 100
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              clear_in,
  input  logic              cfg_valid_in,
  output logic              cfg_ready_out,
  input  logic [ADDR_W-1:0] cfg_addr_in,
  input  logic [DATA_W-1:0] cfg_data_in,
  input  logic              cfg_last_in,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              config_we_out,
  output logic              config_done_out,
  output logic              run_en_out,
  output logic              finished_out,
  output logic [15:0]       words_loaded_out,
  output logic [CNT_W-1:0]  run_cycles_out,
  output logic [DATA_W-1:0] checksum_out
);

  // state      | meaning
  // ST_IDLE    | FIFO empty, waiting for the first host word
  // ST_LOAD    | accepting and replaying words until the last one is driven
  // ST_SETTLE  | settle down-counter running after the last write
  // ST_RUN     | CGRA run window open, run cycles counting
  // ST_DONE    | run limit reached, held until reset or clear
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int ST_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]  SETTLE_LD = ST_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_RUN_CYCLES);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               last_acc_q, last_acc_d;
  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [15:0]        words_q, words_d;
  logic [ST_W-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
  logic               push;
  logic               pop;
  logic               pop_last;

  logic [ADDR_W-1:0]  addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]  data_mem [FIFO_DEPTH];
  logic               last_mem [FIFO_DEPTH];

`ifdef CFG_CHECKSUM_EN
  logic [DATA_W-1:0]  chk_q, chk_d;
`endif

  // Storage is not reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk_in) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= cfg_addr_in;
      data_mem[wr_ptr_q] <= cfg_data_in;
      last_mem[wr_ptr_q] <= cfg_last_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    last_acc_d   = last_acc_q;
    we_d         = 1'b0;
    addr_d       = '0;
    data_d       = '0;
    words_d      = words_q;
    settle_d     = settle_q;
    run_cycles_d = run_cycles_q;
`ifdef CFG_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    push     = cfg_valid_in && ready_q && !clear_in;
    pop      = (occ_q != '0) && !clear_in;
    pop_last = pop && last_mem[rd_ptr_q];

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (cfg_last_in) begin
        last_acc_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      we_d     = 1'b1;
      addr_d   = addr_mem[rd_ptr_q];
      data_d   = data_mem[rd_ptr_q];
      if (words_q != 16'hFFFF) begin
        words_d = words_q + 16'd1;
      end
`ifdef CFG_CHECKSUM_EN
      chk_d = chk_q ^ data_mem[rd_ptr_q];
`endif
    end

    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);

    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (pop_last) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LD;
        end
      end
      // The last write is on the bus during the first SETTLE cycle, so a zero
      // load still opens the run window one cycle after that write.
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q - ST_W'(1);
        end
      end
      ST_RUN: begin
        if (run_cycles_q != '1) begin
          run_cycles_d = run_cycles_q + CNT_W'(1);
        end
        if ((MAX_RUN_CYCLES != 0) && (run_cycles_d == RUN_LIMIT)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear_in) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      occ_d        = '0;
      last_acc_d   = 1'b0;
      we_d         = 1'b0;
      addr_d       = '0;
      data_d       = '0;
      words_d      = '0;
      settle_d     = '0;
      run_cycles_d = '0;
`ifdef CFG_CHECKSUM_EN
      chk_d        = '0;
`endif
    end

    ready_d = (occ_d != OCC_FULL) && !last_acc_d &&
              ((state_d == ST_IDLE) || (state_d == ST_LOAD));
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      last_acc_q   <= 1'b0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      words_q      <= '0;
      settle_q     <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      last_acc_q   <= last_acc_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      words_q      <= words_d;
      settle_q     <= settle_d;
      run_cycles_q <= run_cycles_d;
    end
  end

`ifdef CFG_CHECKSUM_EN
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end
  assign checksum_out = chk_q;
`else
  assign checksum_out = '0;
`endif

  assign cfg_ready_out    = ready_q;
  assign config_we_out    = we_q;
  assign config_addr_out  = addr_q;
  assign config_data_out  = data_q;
  assign words_loaded_out = words_q;
  assign run_cycles_out   = run_cycles_q;
  assign run_en_out       = (state_q == ST_RUN);
  assign finished_out     = (state_q == ST_DONE);
  assign config_done_out  = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule
